// File: rtl/comb_bank_scheduler.sv
// Time-multiplexed scheduler for a bank of feedback comb filters sharing one delay BRAM and one multiplier.
// Each sample tick walks every channel through READ/WAIT/MAC/WRITE, then publishes the bank average.
module comb_bank_scheduler #(
    parameter int WIDTH       = 24,
    parameter int FIXED_POINT = 8,
    parameter int N_CH        = 4,
    parameter int MAXLEN      = 4096,
    parameter int AW          = $clog2(N_CH * MAXLEN),
    localparam int WORD       = WIDTH + FIXED_POINT,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic [WORD-1:0] in,
    input  logic            cfg_we,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [WORD-1:0] cfg_tau,
    input  logic [WORD-1:0] cfg_gain,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_re,
    input  logic [WORD-1:0] mem_rdata,
    output logic            mem_we,
    output logic [WORD-1:0] mem_wdata,
    output logic [WORD-1:0] out,
    output logic            out_valid,
    output logic            busy,
    output logic            overrun
);

    localparam int LOG_N = $clog2(N_CH);
    localparam int ACCW  = WORD + LOG_N;
    localparam int PRW   = 2 * WORD;
    localparam int PW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int TW    = PW + 1;
    localparam int AXW   = AW + CW;
    localparam int CNW   = AW + 1;
    localparam int DEPTH = N_CH * MAXLEN;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_READ, S_WAIT, S_MAC, S_WRITE, S_DONE
    } state_t;

    state_t            state;
    logic [CNW-1:0]    clr_cnt;
    logic [CW-1:0]     ch;
    logic [CW-1:0]     ch_nxt;
    logic [WORD-1:0]   in_lat;
    logic [WORD-1:0]   y_q;
    logic signed [ACCW-1:0] acc;
    logic signed [PRW-1:0]  prod;
    logic [WORD-1:0]   fb_word;
    logic [TW-1:0]     ptr_inc;

    logic [TW-1:0]     tau_sh   [N_CH];
    logic [WORD-1:0]   gain_sh  [N_CH];
    logic [TW-1:0]     tau_act  [N_CH];
    logic [WORD-1:0]   gain_act [N_CH];
    logic [PW-1:0]     ptr      [N_CH];
    logic [PW-1:0]     ptr_load [N_CH];

    function automatic logic [TW-1:0] clamp_tau(input logic [WORD-1:0] t);
        if (t == '0) return TW'(1);
        if (t > WORD'(MAXLEN)) return TW'(MAXLEN);
        return t[TW-1:0];
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] c, input logic [PW-1:0] p);
        logic [AXW-1:0] a;
        a = (AXW'(c) << PW) | AXW'(p);
        return a[AW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                tau_sh[i]  <= TW'(1);
                gain_sh[i] <= '0;
            end
        end else if (cfg_we) begin
            tau_sh[cfg_ch]  <= clamp_tau(cfg_tau);
            gain_sh[cfg_ch] <= cfg_gain;
        end
    end

    // Pointers that would sit outside a shrunken delay line restart at the line head.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ptr_load[i] = (TW'(ptr[i]) >= tau_sh[i]) ? '0 : ptr[i];
        end
    end

    assign ch_nxt  = ch + CW'(1);
    assign ptr_inc = TW'(ptr[ch]) + TW'(1);
    assign prod    = PRW'($signed(gain_act[ch])) * PRW'($signed(y_q));
    assign fb_word = in_lat + WORD'(prod >>> FIXED_POINT);

    // sample_tick has no ready: it is taken only in IDLE; in a processing state it is dropped
    // and flagged on overrun, and during CLEAR it is dropped silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            ch        <= '0;
            in_lat    <= '0;
            y_q       <= '0;
            acc       <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ptr[i]      <= '0;
                tau_act[i]  <= TW'(1);
                gain_act[i] <= '0;
            end
        end else begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b0;
            if (sample_tick && state != S_CLEAR && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == CNW'(DEPTH)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        mem_addr  <= clr_cnt[AW-1:0];
                        mem_we    <= 1'b1;
                        mem_wdata <= '0;
                        busy      <= 1'b1;
                        clr_cnt   <= clr_cnt + CNW'(1);
                    end
                end
                S_IDLE: begin
                    if (sample_tick) begin
                        in_lat <= in;
                        acc    <= '0;
                        ch     <= '0;
                        busy   <= 1'b1;
                        for (int i = 0; i < N_CH; i++) begin
                            tau_act[i]  <= tau_sh[i];
                            gain_act[i] <= gain_sh[i];
                            ptr[i]      <= ptr_load[i];
                        end
                        mem_addr <= addr_of('0, ptr_load[0]);
                        mem_re   <= 1'b1;
                        state    <= S_READ;
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    y_q   <= mem_rdata;
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc       <= acc + ACCW'($signed(y_q));
                    mem_wdata <= fb_word;
                    mem_we    <= 1'b1;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    ptr[ch] <= (ptr_inc == tau_act[ch]) ? '0 : ptr_inc[PW-1:0];
                    if (ch == CW'(N_CH - 1)) begin
                        state <= S_DONE;
                    end else begin
                        ch       <= ch_nxt;
                        mem_addr <= addr_of(ch_nxt, ptr[ch_nxt]);
                        mem_re   <= 1'b1;
                        state    <= S_READ;
                    end
                end
                S_DONE: begin
                    out       <= WORD'(acc >>> LOG_N);
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_bank_scheduler.sv
// Bench for comb_bank_scheduler: BRAM model, vector tables per scenario, and a queue scoreboard
// that pairs every accepted tick with its out_valid result.
`timescale 1ns/1ps
module tb_comb_bank_scheduler;

    localparam int WORD   = 32;
    localparam int N_CH   = 4;
    localparam int MAXLEN = 4096;
    localparam int AW     = 14;
    localparam int CW     = 2;
    localparam int DEPTH  = N_CH * MAXLEN;
    localparam int LAT    = 4 * N_CH + 2;

    typedef struct {
        logic [WORD-1:0] din;
        logic [WORD-1:0] exp_out;
        logic [WORD-1:0] exp_w0;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            sample_tick = 1'b0;
    logic [WORD-1:0] din = '0;
    logic            cfg_we = 1'b0;
    logic [CW-1:0]   cfg_ch = '0;
    logic [WORD-1:0] cfg_tau = '0;
    logic [WORD-1:0] cfg_gain = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_re;
    logic [WORD-1:0] mem_rdata = '0;
    logic            mem_we;
    logic [WORD-1:0] mem_wdata;
    logic [WORD-1:0] dout;
    logic            out_valid;
    logic            busy;
    logic            overrun;

    comb_bank_scheduler dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .in(din),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tau(cfg_tau), .cfg_gain(cfg_gain),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .out(dout), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WORD-1:0] mem_model [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr];
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [WORD-1:0] exp_q [$];
    int              tick_q [$];
    logic [WORD-1:0] wd_q [$];
    logic [AW-1:0]   rd_log [$];
    logic [AW-1:0]   wr_log [$];
    int re_cnt = 0;
    int we_cnt = 0;
    int both_cnt = 0;
    bit pass_mon = 1'b0;
    bit wr_chk = 1'b0;

    vec_t imp_tab [7];
    vec_t neg_tab [5];
    logic [WORD-1:0] t5_exp_out [8];
    int              t5_exp_a0 [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // scoreboard side: pops one expectation per out_valid
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re && mem_we) both_cnt++;
            if (mem_re) begin
                re_cnt++;
                rd_log.push_back(mem_addr);
            end
            if (mem_we && pass_mon) begin
                we_cnt++;
                wr_log.push_back(mem_addr);
                if (wr_chk && mem_addr < AW'(MAXLEN)) begin
                    if (wd_q.size() == 0) note_fail("ch0_write_unexpected");
                    else check("ch0_wdata", mem_wdata, wd_q.pop_front());
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    note_fail("out_valid_unexpected");
                end else begin
                    check("out", dout, exp_q.pop_front());
                    check("latency", 64'(cyc - tick_q.pop_front()), 64'(LAT));
                    check("reads_per_pass", 64'(re_cnt), 64'(N_CH));
                    check("writes_per_pass", 64'(we_cnt), 64'(N_CH));
                end
            end
        end
    end

    // driver tasks
    task automatic cfg(input int c, input logic [WORD-1:0] tau, input logic [WORD-1:0] gain);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = CW'(c); cfg_tau = tau; cfg_gain = gain;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_tick(input logic [WORD-1:0] v, input logic [WORD-1:0] e_out,
                           input bit chk_w, input logic [WORD-1:0] e_w,
                           input bit cfg_en, input int cfg_c, input logic [WORD-1:0] cfg_t);
        @(negedge clk);
        re_cnt = 0; we_cnt = 0;
        rd_log.delete(); wr_log.delete();
        exp_q.push_back(e_out);
        tick_q.push_back(cyc);
        if (chk_w) wd_q.push_back(e_w);
        din = v; sample_tick = 1'b1;
        if (cfg_en) begin
            cfg_we = 1'b1; cfg_ch = CW'(cfg_c); cfg_tau = cfg_t; cfg_gain = '0;
        end
        @(negedge clk);
        sample_tick = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            note_fail("pass_timeout");
            exp_q.delete(); tick_q.delete(); wd_q.delete();
        end
    endtask

    task automatic clear_check(input string tag);
        int bad;
        bad = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (!(mem_we === 1'b1 && mem_re === 1'b0 && busy === 1'b1 &&
                  mem_addr === AW'(k) && mem_wdata === '0)) bad++;
            if (k == 100) sample_tick = 1'b1;
            else if (k == 101) sample_tick = 1'b0;
        end
        check({tag, "_sequence_errors"}, 64'(bad), 64'(0));
        @(negedge clk);
        check({tag, "_idle_after_clear"}, {busy, mem_we}, 0);
        check({tag, "_tick_in_clear_no_overrun"}, overrun, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        imp_tab[0] = '{WORD'(1000), WORD'(0),   WORD'(1000)};
        imp_tab[1] = '{WORD'(0),    WORD'(750), WORD'(0)};
        imp_tab[2] = '{WORD'(0),    WORD'(0),   WORD'(0)};
        imp_tab[3] = '{WORD'(0),    WORD'(250), WORD'(500)};
        imp_tab[4] = '{WORD'(0),    WORD'(0),   WORD'(0)};
        imp_tab[5] = '{WORD'(0),    WORD'(0),   WORD'(0)};
        imp_tab[6] = '{WORD'(0),    WORD'(125), WORD'(250)};
        neg_tab[0] = '{WORD'(-2000), WORD'(0),     WORD'(-2000)};
        neg_tab[1] = '{WORD'(-2000), WORD'(-2000), WORD'(0)};
        neg_tab[2] = '{WORD'(-2000), WORD'(-1500), WORD'(-2000)};
        neg_tab[3] = '{WORD'(-2000), WORD'(-2000), WORD'(0)};
        neg_tab[4] = '{WORD'(-2000), WORD'(-1500), WORD'(-2000)};
        for (int u = 0; u < 8; u++) t5_exp_out[u] = (u == 0) ? WORD'(-2000) : WORD'(0);
        t5_exp_a0 = '{0, 1, 2, 3, 4, 5, 6, 0};
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;

        // reset state and initial clear
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {mem_re, mem_we, out_valid, busy, overrun}, 0);
        check("reset_bus", {mem_addr, mem_wdata}, 0);
        check("reset_out", dout, 0);
        clear_check("clear");

        // impulse response, plus first-pass address order
        pass_mon = 1'b1; wr_chk = 1'b1;
        cfg(0, WORD'(3), WORD'(128));
        for (int k = 0; k < 7; k++) begin
            do_tick(imp_tab[k].din, imp_tab[k].exp_out, 1'b1, imp_tab[k].exp_w0, 1'b0, 0, '0);
            wait_done();
            if (k == 0) begin
                for (int c = 0; c < N_CH; c++) begin
                    check("t0_read_addr", (rd_log.size() > c) ? 64'(rd_log[c]) : 64'hdead, 64'(c * MAXLEN));
                    check("t0_write_addr", (wr_log.size() > c) ? 64'(wr_log[c]) : 64'hdead, 64'(c * MAXLEN));
                end
            end
        end

        // overrun: second tick 5 cycles into a pass
        @(negedge clk);
        check("overrun_clear_before", overrun, 0);
        do_tick(WORD'(0), WORD'(0), 1'b1, WORD'(0), 1'b0, 0, '0);
        repeat (4) @(negedge clk);
        din = WORD'(12345); sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("overrun_set", overrun, 1);
        wait_done();
        repeat (30) @(negedge clk);
        check("no_second_pass_reads", 64'(re_cnt), 64'(N_CH));
        check("idle_after_overrun_pass", busy, 0);
        check("overrun_sticky", overrun, 1);

        // reset in the middle of a pass restarts the clear
        do_tick(WORD'(0), WORD'(0), 1'b1, WORD'(0), 1'b0, 0, '0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midpass_reset_ctrl", {mem_re, mem_we, out_valid, busy, overrun}, 0);
        exp_q.delete(); tick_q.delete(); wd_q.delete();
        pass_mon = 1'b0;
        clear_check("reclear");

        // negative feedback gain
        pass_mon = 1'b1; wr_chk = 1'b1;
        cfg(0, WORD'(1), WORD'(-256));
        for (int k = 0; k < 5; k++) begin
            do_tick(neg_tab[k].din, neg_tab[k].exp_out, 1'b1, neg_tab[k].exp_w0, 1'b0, 0, '0);
            wait_done();
        end

        // config race and tau shrink; tau 0 and oversized tau clamp
        wr_chk = 1'b0;
        cfg(0, WORD'(8), WORD'(0));
        cfg(1, WORD'(0), WORD'(0));
        cfg(2, WORD'(65538), WORD'(0));
        for (int u = 0; u < 8; u++) begin
            do_tick(WORD'(0), t5_exp_out[u], 1'b0, '0, (u == 6), 0, WORD'(4));
            wait_done();
            check("race_ch0_read_addr", (rd_log.size() > 0) ? 64'(rd_log[0]) : 64'hdead, 64'(t5_exp_a0[u]));
            check("race_ch0_write_addr", (wr_log.size() > 0) ? 64'(wr_log[0]) : 64'hdead, 64'(t5_exp_a0[u]));
            check("tau0_ch1_read_addr", (rd_log.size() > 1) ? 64'(rd_log[1]) : 64'hdead, 64'(MAXLEN));
            check("tau_clamp_ch2_read_addr", (rd_log.size() > 2) ? 64'(rd_log[2]) : 64'hdead, 64'(2 * MAXLEN + u));
        end

        // final report
        repeat (2) @(negedge clk);
        check("re_we_never_both", 64'(both_cnt), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
